autoanim_multi: RTL and testbench

// - Multi-channel, parametrised auto-animation frame counter for the LSPC video path.
// - Each channel advances a tile-index counter once every (SPEED+1) frame ticks.
// - Adds per-channel enable, limit, resync and (optional) ping-pong sequencing.
// - Index output feeds sprite tile-number substitution (low COUNT_W tile bits).

---
 rtl/autoanim_pkg.sv | 19 +
 rtl/autoanim_if.sv | 34 +++
 rtl/autoanim_channel.sv | 111 +++++++++++
 rtl/autoanim_multi.sv | 39 +++
 tb/tb_autoanim_multi.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/autoanim_pkg.sv
// autoanim_pkg: shared constants for the multi-channel auto-animation counter.
//   - AA_MODE_WRAP / AA_MODE_PINGPONG : encodings of a CH_MODE bit
//   - aa_dir_e                        : ping-pong direction (up / down)
//   - AA_* width constants            : default parameter values
package autoanim_pkg;

    localparam int AA_CHANNELS   = 2;
    localparam int AA_PRESCALE_W = 8;
    localparam int AA_COUNT_W    = 3;

    localparam logic AA_MODE_WRAP     = 1'b0;
    localparam logic AA_MODE_PINGPONG = 1'b1;

    typedef enum logic {
        AA_DIR_UP   = 1'b0,
        AA_DIR_DOWN = 1'b1
    } aa_dir_e;

endpackage

// File: rtl/autoanim_if.sv
// autoanim_if: bus bundle between the frame-timing logic and the animation block.
//   master : drives FRAME_TICK, CH_EN, CH_SYNC, CH_SPEED, CH_LIMIT, CH_MODE;
//            receives AA_COUNT, AA_STEP
//   slave  : the animation block (autoanim_multi)
// Signalling: there is no valid/ready pair. FRAME_TICK and CH_SYNC are
// single-CLK pulses that are acted on at the rising edge that samples them;
// the configuration buses are level signals sampled live on every edge.
// AA_STEP is a single-CLK pulse that rises with the new AA_COUNT value.
interface autoanim_if
    import autoanim_pkg::*;
#(
    parameter int CHANNELS   = AA_CHANNELS,
    parameter int PRESCALE_W = AA_PRESCALE_W,
    parameter int COUNT_W    = AA_COUNT_W
);
    logic                           FRAME_TICK;
    logic [CHANNELS-1:0]            CH_EN;
    logic [CHANNELS-1:0]            CH_SYNC;
    logic [CHANNELS*PRESCALE_W-1:0] CH_SPEED;
    logic [CHANNELS*COUNT_W-1:0]    CH_LIMIT;
    logic [CHANNELS-1:0]            CH_MODE;
    logic [CHANNELS*COUNT_W-1:0]    AA_COUNT;
    logic [CHANNELS-1:0]            AA_STEP;

    modport master (
        output FRAME_TICK, CH_EN, CH_SYNC, CH_SPEED, CH_LIMIT, CH_MODE,
        input  AA_COUNT, AA_STEP
    );

    modport slave (
        input  FRAME_TICK, CH_EN, CH_SYNC, CH_SPEED, CH_LIMIT, CH_MODE,
        output AA_COUNT, AA_STEP
    );
endinterface

// File: rtl/autoanim_channel.sv
// autoanim_channel: one animation channel (prescaler + tile index + direction).
//   CLK, nRESET : clock, asynchronous active-low reset
//   frame_tick  : one-CLK frame pulse
//   en, sync    : run enable, resync pulse (sync has priority)
//   speed       : frames-per-step minus 1
//   limit       : last index of the sequence
//   mode        : AA_MODE_WRAP / AA_MODE_PINGPONG
//   count, step : registered tile index, one-CLK step pulse
// Optional feature macro: AA_PINGPONG_EN (adds the direction flop and honours
// mode). Without it every channel wraps and mode is ignored.
module autoanim_channel
    import autoanim_pkg::*;
#(
    parameter int PRESCALE_W = AA_PRESCALE_W,
    parameter int COUNT_W    = AA_COUNT_W
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  frame_tick,
    input  logic                  en,
    input  logic                  sync,
    input  logic [PRESCALE_W-1:0] speed,
    input  logic [COUNT_W-1:0]    limit,
    input  logic                  mode,
    output logic [COUNT_W-1:0]    count,
    output logic                  step
);

    logic [PRESCALE_W-1:0] prescaler;
    logic [COUNT_W-1:0]    count_nxt;

`ifdef AA_PINGPONG_EN
    aa_dir_e dir;
    aa_dir_e dir_nxt;

    // Next index for a step. LIMIT=0 pins the index at 0 in both modes; the
    // ">=" compares keep the index from running past a LIMIT that was lowered
    // below the current count.
    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        if (limit == '0) begin
            count_nxt = '0;
            dir_nxt   = AA_DIR_UP;
        end else if (mode == AA_MODE_PINGPONG) begin
            if (dir == AA_DIR_UP) begin
                if (count >= limit) begin
                    dir_nxt   = AA_DIR_DOWN;
                    count_nxt = limit - COUNT_W'(1);
                end else begin
                    count_nxt = count + COUNT_W'(1);
                end
            end else begin
                if (count == '0) begin
                    dir_nxt   = AA_DIR_UP;
                    count_nxt = COUNT_W'(1);
                end else begin
                    count_nxt = count - COUNT_W'(1);
                end
            end
        end else begin
            // Wrap mode leaves dir untouched so a later switch back to
            // ping-pong resumes in the same direction.
            count_nxt = (count >= limit) ? '0 : count + COUNT_W'(1);
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        count_nxt = (count >= limit) ? '0 : count + COUNT_W'(1);
    end
`endif

    // Prescaler counts down to 0; the tick that finds it at 0 steps and
    // reloads, so the period is speed+1 ticks and the first tick after
    // reset steps immediately.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            prescaler <= '0;
            count     <= '0;
            step      <= 1'b0;
`ifdef AA_PINGPONG_EN
            dir       <= AA_DIR_UP;
`endif
        end else if (sync) begin
            prescaler <= speed;
            count     <= '0;
            step      <= 1'b0;
`ifdef AA_PINGPONG_EN
            dir       <= AA_DIR_UP;
`endif
        end else if (frame_tick && en) begin
            if (prescaler != '0) begin
                prescaler <= prescaler - PRESCALE_W'(1);
                step      <= 1'b0;
            end else begin
                prescaler <= speed;
                count     <= count_nxt;
                step      <= 1'b1;
`ifdef AA_PINGPONG_EN
                dir       <= dir_nxt;
`endif
            end
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/autoanim_multi.sv
// autoanim_multi: multi-channel auto-animation frame counter for the LSPC
// video path. Each channel steps a tile index once every SPEED+1 frame ticks.
//   CLK    : system clock, all state on the rising edge
//   nRESET : asynchronous active-low reset
//   bus    : autoanim_if slave (FRAME_TICK, CH_EN, CH_SYNC, CH_SPEED,
//            CH_LIMIT, CH_MODE in; AA_COUNT, AA_STEP out)
// Optional feature macro: AA_PINGPONG_EN (ping-pong sequencing per CH_MODE).
// The top only slices the packed buses; all behaviour lives in the channels.
module autoanim_multi
    import autoanim_pkg::*;
#(
    parameter int CHANNELS   = AA_CHANNELS,
    parameter int PRESCALE_W = AA_PRESCALE_W,
    parameter int COUNT_W    = AA_COUNT_W
) (
    input  logic       CLK,
    input  logic       nRESET,
    autoanim_if.slave  bus
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        autoanim_channel #(
            .PRESCALE_W (PRESCALE_W),
            .COUNT_W    (COUNT_W)
        ) u_channel (
            .CLK        (CLK),
            .nRESET     (nRESET),
            .frame_tick (bus.FRAME_TICK),
            .en         (bus.CH_EN[g]),
            .sync       (bus.CH_SYNC[g]),
            .speed      (bus.CH_SPEED[g*PRESCALE_W +: PRESCALE_W]),
            .limit      (bus.CH_LIMIT[g*COUNT_W +: COUNT_W]),
            .mode       (bus.CH_MODE[g]),
            .count      (bus.AA_COUNT[g*COUNT_W +: COUNT_W]),
            .step       (bus.AA_STEP[g])
        );
    end

endmodule

// File: tb/tb_autoanim_multi.sv
// tb_autoanim_multi: self-checking bench for autoanim_multi.
// Directed scenarios check the documented sequences; a random phase checks
// both channels every cycle against a behavioural model of the channel rules.
module tb_autoanim_multi;

    localparam int CH = 2;
    localparam int PW = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    autoanim_if #(.CHANNELS(CH), .PRESCALE_W(PW), .COUNT_W(CW)) bus();

    autoanim_multi #(.CHANNELS(CH), .PRESCALE_W(PW), .COUNT_W(CW)) dut (
        .CLK    (clk),
        .nRESET (nreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_pre [CH];
    int m_cnt [CH];
    int m_down[CH];
    int m_stp [CH];

    logic [CW-1:0] exp_q[$];

    function automatic int get_cnt(input int ch);
        logic [CW-1:0] v;
        v = bus.AA_COUNT[ch*CW +: CW];
        return int'(v);
    endfunction

    function automatic int get_stp(input int ch);
        return int'(bus.AA_STEP[ch]);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_pre[c]  = 0;
            m_cnt[c]  = 0;
            m_down[c] = 0;
            m_stp[c]  = 0;
        end
    endfunction

    // One clock of the channel rules, evaluated from the current inputs.
    function automatic void model_clk();
        int spd, lim;
        for (int c = 0; c < CH; c++) begin
            spd = int'(bus.CH_SPEED[c*PW +: PW]);
            lim = int'(bus.CH_LIMIT[c*CW +: CW]);
            if (bus.CH_SYNC[c]) begin
                m_pre[c] = spd; m_cnt[c] = 0; m_down[c] = 0; m_stp[c] = 0;
            end else if (bus.FRAME_TICK && bus.CH_EN[c]) begin
                if (m_pre[c] > 0) begin
                    m_pre[c] = m_pre[c] - 1;
                    m_stp[c] = 0;
                end else begin
                    m_pre[c] = spd;
                    m_stp[c] = 1;
                    if (lim == 0) begin
                        m_cnt[c] = 0; m_down[c] = 0;
`ifdef AA_PINGPONG_EN
                    end else if (bus.CH_MODE[c]) begin
                        if (m_down[c] == 0) begin
                            if (m_cnt[c] >= lim) begin m_down[c] = 1; m_cnt[c] = lim - 1; end
                            else m_cnt[c] = m_cnt[c] + 1;
                        end else begin
                            if (m_cnt[c] == 0) begin m_down[c] = 0; m_cnt[c] = 1; end
                            else m_cnt[c] = m_cnt[c] - 1;
                        end
`endif
                    end else begin
                        m_cnt[c] = (m_cnt[c] >= lim) ? 0 : m_cnt[c] + 1;
                    end
                end
            end else begin
                m_stp[c] = 0;
            end
        end
    endfunction

    task automatic set_ch(input int ch, input logic en, input int speed,
                          input int limit, input logic mode);
        bus.CH_EN[ch]             = en;
        bus.CH_SPEED[ch*PW +: PW] = PW'(speed);
        bus.CH_LIMIT[ch*CW +: CW] = CW'(limit);
        bus.CH_MODE[ch]           = mode;
    endtask

    // Called at a negedge; returns at the following negedge with outputs settled.
    task automatic cycle(input logic tick, input logic [CH-1:0] sync);
        bus.FRAME_TICK = tick;
        bus.CH_SYNC    = sync;
        @(posedge clk);
        model_clk();
        @(negedge clk);
        bus.FRAME_TICK = 1'b0;
        bus.CH_SYNC    = '0;
    endtask

    task automatic do_reset();
        nreset         = 1'b0;
        bus.FRAME_TICK = 1'b0;
        bus.CH_EN      = '0;
        bus.CH_SYNC    = '0;
        bus.CH_SPEED   = '0;
        bus.CH_LIMIT   = '0;
        bus.CH_MODE    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (get_cnt(c) !== 0 || get_stp(c) !== 0) begin
                errors++;
                $display("FAIL reset_state ch%0d got cnt=%0d stp=%0d exp 0/0", c, get_cnt(c), get_stp(c));
            end
        end
        set_ch(0, 1'b1, 0, 7, 1'b0);
        repeat (3) cycle(1'b1, '0);
        nreset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (get_cnt(0) !== 0 || get_stp(0) !== 0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d stp=%0d exp 0/0", get_cnt(0), get_stp(0));
        end
        @(negedge clk);
        nreset = 1'b1;
        cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 1 || get_stp(0) !== 1) begin
            errors++;
            $display("FAIL first_tick_after_reset got cnt=%0d stp=%0d exp 1/1", get_cnt(0), get_stp(0));
        end
    endtask

    task automatic test_wrap_speed0();
        logic [CW-1:0] e;
        do_reset();
        set_ch(0, 1'b1, 0, 7, 1'b0);
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, '0);
            e = exp_q.pop_front();
            checks++;
            if (get_cnt(0) !== int'(e) || get_stp(0) !== 1) begin
                errors++;
                $display("FAIL wrap_speed0 tick%0d got cnt=%0d stp=%0d exp %0d/1", k, get_cnt(0), get_stp(0), e);
            end
        end
        cycle(1'b0, '0);
        checks++;
        if (get_stp(0) !== 0 || get_cnt(1) !== 0) begin
            errors++;
            $display("FAIL idle_after_wrap got stp0=%0d cnt1=%0d exp 0/0", get_stp(0), get_cnt(1));
        end
    endtask

    task automatic test_speed3();
        logic [CW-1:0] e;
        int last;
        do_reset();
        set_ch(0, 1'b1, 3, 5, 1'b0);
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        last = 0;
        for (int k = 0; k < 24; k++) begin
            cycle(1'b1, '0);
            if (k % 4 == 0) begin
                e = exp_q.pop_front();
                last = int'(e);
            end
            checks++;
            if (get_cnt(0) !== last || get_stp(0) !== int'(k % 4 == 0)) begin
                errors++;
                $display("FAIL speed3 tick%0d got cnt=%0d stp=%0d exp %0d/%0d", k, get_cnt(0), get_stp(0), last, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_speed_max();
        do_reset();
        set_ch(0, 1'b1, 255, 7, 1'b0);
        cycle(1'b1, '0);
        repeat (255) cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 1 || get_stp(0) !== 0) begin
            errors++;
            $display("FAIL speed255_hold got cnt=%0d stp=%0d exp 1/0", get_cnt(0), get_stp(0));
        end
        cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 2 || get_stp(0) !== 1) begin
            errors++;
            $display("FAIL speed255_step got cnt=%0d stp=%0d exp 2/1", get_cnt(0), get_stp(0));
        end
    endtask

    task automatic test_pingpong();
        logic [CW-1:0] e;
        do_reset();
        set_ch(0, 1'b1, 0, 3, 1'b1);
`ifdef AA_PINGPONG_EN
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
`else
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
`endif
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, '0);
            e = exp_q.pop_front();
            checks++;
            if (get_cnt(0) !== int'(e)) begin
                errors++;
                $display("FAIL pingpong tick%0d got %0d exp %0d", k, get_cnt(0), e);
            end
        end
    endtask

    task automatic test_sync_enable();
        do_reset();
        set_ch(0, 1'b1, 0, 7, 1'b0);
        repeat (3) cycle(1'b1, '0);
        cycle(1'b1, 2'b01);
        checks++;
        if (get_cnt(0) !== 0 || get_stp(0) !== 0) begin
            errors++;
            $display("FAIL sync_with_tick got cnt=%0d stp=%0d exp 0/0", get_cnt(0), get_stp(0));
        end
        set_ch(0, 1'b1, 2, 7, 1'b0);
        cycle(1'b1, '0);
        cycle(1'b1, '0);
        bus.CH_EN[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, '0);
            checks++;
            if (get_cnt(0) !== 1 || get_stp(0) !== 0) begin
                errors++;
                $display("FAIL disabled_freeze tick%0d got cnt=%0d stp=%0d exp 1/0", k, get_cnt(0), get_stp(0));
            end
        end
        bus.CH_EN[0] = 1'b1;
        cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 1 || get_stp(0) !== 0) begin
            errors++;
            $display("FAIL resume_prescale got cnt=%0d stp=%0d exp 1/0", get_cnt(0), get_stp(0));
        end
        cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 2 || get_stp(0) !== 1) begin
            errors++;
            $display("FAIL resume_step got cnt=%0d stp=%0d exp 2/1", get_cnt(0), get_stp(0));
        end
    endtask

    task automatic test_limit_lower();
        do_reset();
        set_ch(0, 1'b1, 0, 7, 1'b0);
        repeat (5) cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 5) begin
            errors++;
            $display("FAIL limit_pre got %0d exp 5", get_cnt(0));
        end
        bus.CH_LIMIT[0 +: CW] = 3'd2;
        cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 0) begin
            errors++;
            $display("FAIL limit_lowered got %0d exp 0", get_cnt(0));
        end
        cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 1) begin
            errors++;
            $display("FAIL limit_after got %0d exp 1", get_cnt(0));
        end
    endtask

    task automatic test_independent();
        do_reset();
        set_ch(0, 1'b1, 0, 7, 1'b0);
        set_ch(1, 1'b1, 2, 3, 1'b0);
        repeat (12) cycle(1'b1, '0);
        checks++;
        if (get_cnt(0) !== 4 || get_cnt(1) !== 0) begin
            errors++;
            $display("FAIL independent got ch0=%0d ch1=%0d exp 4/0", get_cnt(0), get_cnt(1));
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] sync;
        do_reset();
        for (int c = 0; c < CH; c++) set_ch(c, 1'b1, 0, 7, 1'b0);
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 15) == 0)
                    set_ch(c, 1'b1,
                           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 19) == 0) bus.CH_EN[c] = ~bus.CH_EN[c];
                sync[c] = ($urandom_range(0, 31) == 0);
            end
            cycle(1'($urandom_range(0, 1)), sync);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (get_cnt(c) !== m_cnt[c] || get_stp(c) !== m_stp[c]) begin
                    errors++;
                    $display("FAIL random cyc%0d ch%0d got cnt=%0d stp=%0d exp %0d/%0d",
                             k, c, get_cnt(c), get_stp(c), m_cnt[c], m_stp[c]);
                end
            end
        end
    endtask

    initial begin
        nreset = 1'b0;
        @(negedge clk);
        test_reset();
        test_wrap_speed0();
        test_speed3();
        test_speed_max();
        test_pingpong();
        test_sync_enable();
        test_limit_lower();
        test_independent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
